// File: rtl/sdadc_pkg.sv
// Shared scale constants for the sigma-delta ADC, as functions of the output MSB index.
package sdadc_pkg;

  function automatic int unsigned sdadc_mid_scale(input int unsigned msbo);
    return 32'd1 << msbo;
  endfunction

  function automatic int unsigned sdadc_full_scale(input int unsigned msbo);
    return (32'd1 << (msbo + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sdadc_sync.sv
// Two-flop synchronizer for the asynchronous comparator input; 2-cycle latency, no backpressure.
module sdadc_sync (
  input  logic CLK_i,
  input  logic RSTn_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC: counts feedback ones over a 2^(MSBO+1)-cycle window, sample 1 cycle after close.
// Valid/ready output; an unconsumed sample is overwritten by the next one and flagged on OVR_o.
// Define SDADC_AVG2_EN to average each count with the previous window's count.
module sigma_delta_adc
  import sdadc_pkg::*;
#(
  parameter int MSBO = 7
) (
  input  logic          CLK_i,
  input  logic          RSTn_i,
  input  logic          CMP_i,
  output logic          FB_o,
  output logic [MSBO:0] SAMPLE_o,
  output logic          VALID_o,
  input  logic          READY_i,
  output logic          OVR_o
);

  localparam logic [MSBO:0] MID_SCALE  = (MSBO + 1)'(sdadc_mid_scale(MSBO));
  localparam logic [MSBO:0] FULL_SCALE = (MSBO + 1)'(sdadc_full_scale(MSBO));

  logic            cmp_sync;
  logic [MSBO:0]   wcnt;
  logic [MSBO+1:0] acc;
  logic [MSBO+1:0] cnt;
  logic [MSBO:0]   sat_cnt;
  logic [MSBO:0]   new_sample;
  logic            term;

  sdadc_sync u_sync (
    .CLK_i  (CLK_i),
    .RSTn_i (RSTn_i),
    .d      (CMP_i),
    .q      (cmp_sync)
  );

  assign term    = &wcnt;
  // The terminal cycle's bit is folded in here so ACC can restart cleanly at 0.
  assign cnt     = acc + (MSBO + 2)'(FB_o);
  assign sat_cnt = cnt[MSBO+1] ? FULL_SCALE : cnt[MSBO:0];

`ifdef SDADC_AVG2_EN
  logic [MSBO:0]   prev_cnt;
  logic [MSBO+1:0] avg_sum;

  assign avg_sum    = (MSBO + 2)'(sat_cnt) + (MSBO + 2)'(prev_cnt);
  assign new_sample = (MSBO + 1)'(avg_sum >> 1);

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      prev_cnt <= MID_SCALE;
    end else if (term) begin
      prev_cnt <= sat_cnt;
    end
  end
`else
  assign new_sample = sat_cnt;
`endif

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      FB_o <= 1'b0;
      wcnt <= '0;
      acc  <= '0;
    end else begin
      FB_o <= cmp_sync;
      wcnt <= wcnt + 1'b1;
      acc  <= term ? '0 : cnt;
    end
  end

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      SAMPLE_o <= MID_SCALE;
      VALID_o  <= 1'b0;
      OVR_o    <= 1'b0;
    end else if (term) begin
      SAMPLE_o <= new_sample;
      VALID_o  <= 1'b1;
      OVR_o    <= VALID_o & ~READY_i;
    end else begin
      OVR_o <= 1'b0;
      if (VALID_o && READY_i) begin
        VALID_o <= 1'b0;
      end
    end
  end

endmodule
